// File: rtl/f2_rr_sched_if.sv
// Bundles the requester, F2-unit and response signals of f2_rr_sched.
// The slave modport is the scheduler's view; the master modport is the
// environment's view (requesters, F2 unit and result consumer).
interface f2_rr_sched_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_f;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic [1:0]            unit_f;
    logic [WIDTH-1:0]      unit_in0;
    logic [WIDTH-1:0]      unit_in2;
    logic [WIDTH-1:0]      unit_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic [CNTW-1:0]       issue_cnt;

    modport slave (
        input  req_valid, req_f, req_a, req_b, unit_out, rsp_ready,
        output req_ready, unit_f, unit_in0, unit_in2, rsp_valid, rsp_data, rsp_id, issue_cnt
    );

    modport master (
        output req_valid, req_f, req_a, req_b, unit_out, rsp_ready,
        input  req_ready, unit_f, unit_in0, unit_in2, rsp_valid, rsp_data, rsp_id, issue_cnt
    );
endinterface

// File: rtl/f2_rr_sched.sv
// Round-robin share of one combinational F2 shift unit among NREQ requesters.
// Latency: 1 cycle from accept to rsp_valid; 1 op/cycle while rsp_ready is high.
// Backpressure: result held and all req_ready low while FULL and rsp_ready is low.
module f2_rr_sched #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    f2_rr_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             gnt_vld;
    logic [IDW-1:0]   gnt_id;
    int               arb_idx;
    logic             rsp_vld;
    logic             can_issue;
    logic             issue;

    assign rsp_vld   = (state_q == FULL);
    assign can_issue = !rsp_vld || bus.rsp_ready;
    // Gated by rst_n so nothing is offered to requesters while reset is held.
    assign issue     = rst_n && can_issue && gnt_vld;

    // Search from ptr_q upward; scanning far-to-near lets the nearest valid requester win.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        arb_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (bus.req_valid[arb_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(arb_idx);
            end
        end
    end

    // Drive the granted requester's ready and operands; everything is zero without an issue.
    always_comb begin
        bus.req_ready = '0;
        bus.unit_f    = '0;
        bus.unit_in0  = '0;
        bus.unit_in2  = '0;
        if (issue) begin
            bus.req_ready[gnt_id] = 1'b1;
            bus.unit_f            = bus.req_f[2*gnt_id +: 2];
            bus.unit_in0          = bus.req_a[WIDTH*gnt_id +: WIDTH];
            bus.unit_in2          = bus.req_b[WIDTH*gnt_id +: WIDTH];
        end
    end

    // Next state: accept reloads the result (even while draining), drain alone empties it.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        cnt_d      = cnt_q;
        if (issue) begin
            state_d    = FULL;
            rsp_data_d = bus.unit_out;
            rsp_id_d   = gnt_id;
            ptr_d      = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            if (cnt_q != {CNTW{1'b1}}) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end else if (rsp_vld && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // State registers; reset drops any held result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.issue_cnt = cnt_q;
endmodule

// File: tb/tb_f2_rr_sched.sv
// Directed bench for f2_rr_sched with a small F2 unit model on the unit side.
// Table of single-op vectors plus hand sequences for reset, fairness,
// backpressure, counter saturation (CNTW=4) and mid-operation reset.
module tb_f2_rr_sched;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int CNTW  = 4;

    logic clk;
    logic rst_n;

    f2_rr_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) bus ();

    f2_rr_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference F2 unit: f[1] picks in2, f[0] picks shift by 1 instead of 3.
    function automatic logic [WIDTH-1:0] f2_ref(input logic [1:0] f,
                                                input logic [WIDTH-1:0] in0,
                                                input logic [WIDTH-1:0] in2);
        logic [WIDTH-1:0] sel;
        sel = f[1] ? in2 : in0;
        return f[0] ? (sel << 1) : (sel << 3);
    endfunction

    assign bus.unit_out = f2_ref(bus.unit_f, bus.unit_in0, bus.unit_in2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic acc_edge();
        @(posedge clk);
        if (exp_cnt < 15) exp_cnt++;
    endtask

    // Present one request; the other lanes carry decoy operands.
    task automatic set_one(input int r, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_f[2*i +: 2]   = 2'b11;
            bus.req_a[32*i +: 32] = 32'hDEAD_0000 | i;
            bus.req_b[32*i +: 32] = 32'hBEEF_0000 | i;
        end
        bus.req_f[2*r +: 2]   = f;
        bus.req_a[32*r +: 32] = a;
        bus.req_b[32*r +: 32] = b;
        bus.req_valid         = 4'(1) << r;
    endtask

    typedef struct {
        int          r;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[8];
    int   fair_id[6];
    logic [31:0] fair_dat[6];

    initial begin
        vt[0] = '{2, 2'b01, 32'h0000_0005, 32'h0000_0000, 32'h0000_000A};
        vt[1] = '{1, 2'b10, 32'h0000_0000, 32'h8000_0001, 32'h0000_0008};
        vt[2] = '{1, 2'b00, 32'hF000_000F, 32'h0000_0000, 32'h8000_0078};
        vt[3] = '{3, 2'b11, 32'h0000_0000, 32'h0000_1234, 32'h0000_2468};
        vt[4] = '{0, 2'b00, 32'h0000_0001, 32'h0000_0000, 32'h0000_0008};
        vt[5] = '{2, 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0008};
        vt[6] = '{0, 2'b01, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
        vt[7] = '{3, 2'b01, 32'h1234_5678, 32'hFFFF_0000, 32'h2468_ACF0};
        fair_id  = '{0, 1, 2, 3, 0, 1};
        fair_dat = '{32'h20, 32'h40, 32'h60, 32'h80, 32'h20, 32'h40};

        // Reset with everyone requesting.
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_f[2*i +: 2]   = 2'b11;
            bus.req_a[32*i +: 32] = 32'h0;
            bus.req_b[32*i +: 32] = (i + 1) << 4;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_issue_cnt", bus.issue_cnt, 4'd0);
        chk("rst_unit_f", bus.unit_f, 2'b00);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("release_grant0", bus.req_ready, 4'b0001);

        // Fairness: all requesting, consumer always ready.
        for (int i = 0; i < 6; i++) begin
            acc_edge();
            @(negedge clk);
            #1;
            chk("fair_valid", bus.rsp_valid, 1'b1);
            chk("fair_id", bus.rsp_id, fair_id[i]);
            chk("fair_data", bus.rsp_data, fair_dat[i]);
        end
        bus.req_valid = 4'h0;
        #1;
        chk("fair_cnt", bus.issue_cnt, exp_cnt);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain_valid", bus.rsp_valid, 1'b0);
        chk("drain_id_hold", bus.rsp_id, 2'd1);
        chk("drain_data_hold", bus.rsp_data, 32'h40);

        // Idle cycles must not rotate the pointer (next is requester 2).
        repeat (3) @(negedge clk);
        bus.req_valid = 4'hF;
        #1;
        chk("idle_ptr", bus.req_ready, 4'b0100);
        bus.req_valid = 4'h0;

        // Table of single operations.
        for (int v = 0; v < 8; v++) begin
            set_one(vt[v].r, vt[v].f, vt[v].a, vt[v].b);
            #1;
            chk("vec_ready", bus.req_ready, 4'(1) << vt[v].r);
            chk("vec_unit_f", bus.unit_f, vt[v].f);
            chk("vec_unit_in0", bus.unit_in0, vt[v].a);
            chk("vec_unit_in2", bus.unit_in2, vt[v].b);
            acc_edge();
            @(negedge clk);
            bus.req_valid = 4'h0;
            #1;
            chk("vec_valid", bus.rsp_valid, 1'b1);
            chk("vec_data", bus.rsp_data, vt[v].exp);
            chk("vec_id", bus.rsp_id, vt[v].r);
        end
        chk("table_cnt", bus.issue_cnt, exp_cnt);

        // Backpressure while holding requester 3's result.
        bus.rsp_ready = 1'b0;
        set_one(0, 2'b01, 32'h0000_0003, 32'h0);
        #1;
        chk("bp_ready0", bus.req_ready, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("bp_data", bus.rsp_data, 32'h2468_ACF0);
            chk("bp_id", bus.rsp_id, 2'd3);
            chk("bp_valid", bus.rsp_valid, 1'b1);
            chk("bp_ready", bus.req_ready, 4'b0000);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.req_ready, 4'b0001);
        acc_edge();
        @(negedge clk);
        #1;
        chk("reload_valid", bus.rsp_valid, 1'b1);
        chk("reload_data", bus.rsp_data, 32'h0000_0006);
        chk("reload_id", bus.rsp_id, 2'd0);
        chk("reload_cnt", bus.issue_cnt, exp_cnt);

        // Keep issuing past the counter limit.
        bus.req_valid = 4'hF;
        repeat (6) begin
            acc_edge();
            @(negedge clk);
        end
        #1;
        chk("sat_cnt", bus.issue_cnt, exp_cnt);
        chk("sat_cnt_max", bus.issue_cnt, 4'hF);

        // Reset mid-operation, between clock edges, while FULL.
        #2;
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        chk("mid_rst_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_cnt", bus.issue_cnt, exp_cnt);
        chk("mid_rst_ready", bus.req_ready, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant0", bus.req_ready, 4'b0001);
        acc_edge();
        @(negedge clk);
        #1;
        chk("post_rst_id", bus.rsp_id, 2'd0);
        chk("post_rst_cnt", bus.issue_cnt, exp_cnt);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
